// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants shared by the VGA sync generator
package vga_timing_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  localparam bit VGA_SYNC_POL = 1'b0;
  localparam int VGA_CNT_W = 10;
  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_HS_END = VGA_HS_START + VGA_H_SYNC;
  localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_VS_END = VGA_VS_START + VGA_V_SYNC;
endpackage

// File: rtl/mod_counter.sv
// mod_counter: enabled modulo counter; en/clk_in/rst in, count, next_count and wrap (en at MODULUS-1) out
module mod_counter #(
  parameter int unsigned MODULUS = 800,
  parameter int unsigned WIDTH = 10,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(MODULUS - 1)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap
);
  logic [WIDTH-1:0] count_q;
  assign count = count_q;
  assign wrap = en && (count_q == WIDTH'(MODULUS - 1));
  assign next_count = wrap ? '0 : en ? count_q + WIDTH'(1) : count_q;
  always_ff @(posedge clk_in) count_q <= rst ? RESET_VAL : next_count;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing from pix_en; outputs hsync/vsync/video_on/pixel_x/pixel_y/frame_start, all registered
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP,
  parameter bit SYNC_POL = VGA_SYNC_POL,
  parameter int CNT_W = VGA_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_ACT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_S = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_E = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_S = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_E = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  logic [CNT_W-1:0] h_d, v_d;
  logic h_wrap, v_wrap;
  logic hsync_q, vsync_q, video_on_q, frame_start_q;
  mod_counter #(.MODULUS(H_TOTAL), .WIDTH(CNT_W), .RESET_VAL(CNT_W'(H_TOTAL - 1))) u_h (
    .clk_in, .rst, .en(pix_en), .count(pixel_x), .next_count(h_d), .wrap(h_wrap)
  );
  mod_counter #(.MODULUS(V_TOTAL), .WIDTH(CNT_W), .RESET_VAL(CNT_W'(V_TOTAL - 1))) u_v (
    .clk_in, .rst, .en(h_wrap), .count(pixel_y), .next_count(v_d), .wrap(v_wrap)
  );
  // decoding the next-state counts keeps every output aligned with pixel_x/pixel_y
  always_ff @(posedge clk_in) begin
    if (rst) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      video_on_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q <= (h_d >= HS_S && h_d < HS_E) ? SYNC_POL : ~SYNC_POL;
      vsync_q <= (v_d >= VS_S && v_d < VS_E) ? SYNC_POL : ~SYNC_POL;
      video_on_q <= (h_d < H_ACT) && (v_d < V_ACT);
      frame_start_q <= h_wrap && v_wrap;
    end
  end
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign video_on = video_on_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of default 640x480 timing and a tiny SYNC_POL=1 build at clk rate
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic rst = 1'b0, pix_en = 1'b0, rst_b = 1'b0, en_b = 1'b0;
  logic hsync, vsync, video_on, frame_start;
  logic [9:0] pixel_x, pixel_y;
  logic hs_b, vs_b, von_b, fs_b;
  logic [9:0] px_b, py_b;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut (
    .clk_in(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1), .CNT_W(10)
  ) dut_b (
    .clk_in(clk), .rst(rst_b), .pix_en(en_b), .hsync(hs_b), .vsync(vs_b),
    .video_on(von_b), .pixel_x(px_b), .pixel_y(py_b), .frame_start(fs_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    repeat (3) @(negedge clk);
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  initial begin
    int hs_low, fs_cnt;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_px", pixel_x, 799);
    chk("rst_py", pixel_y, 524);
    chk("rst_hs", hsync, 1);
    chk("rst_vs", vsync, 1);
    chk("rst_von", video_on, 0);
    chk("rst_fs", frame_start, 0);
    tick();
    chk("first_px", pixel_x, 0);
    chk("first_py", pixel_y, 0);
    chk("first_von", video_on, 1);
    chk("first_fs", frame_start, 1);
    @(negedge clk);
    chk("fs_one_cycle", frame_start, 0);
    tick();
    chk("second_px", pixel_x, 1);
    chk("second_fs", frame_start, 0);
    hs_low = 0;
    for (int x = 2; x < 800; x++) begin
      tick();
      chk("line_px", pixel_x, x);
      chk("line_py", pixel_y, 0);
      chk("line_hs", hsync, (x >= 656 && x < 752) ? 0 : 1);
      chk("line_von", video_on, (x < 640) ? 1 : 0);
      chk("line_vs", vsync, 1);
      chk("line_fs", frame_start, 0);
      if (hsync == 1'b0) hs_low++;
      if (x == 300) begin
        repeat (100) begin
          @(negedge clk);
          chk("hold_px", pixel_x, 300);
          chk("hold_von", video_on, 1);
          chk("hold_hs", hsync, 1);
          chk("hold_fs", frame_start, 0);
        end
      end
    end
    chk("hs_low_ticks", hs_low, 96);
    tick();
    chk("hwrap_px", pixel_x, 0);
    chk("hwrap_py", pixel_y, 1);
    chk("hwrap_von", video_on, 1);
    chk("hwrap_fs", frame_start, 0);
    for (int x = 1; x <= 700; x++) tick();
    chk("mid_px", pixel_x, 700);
    chk("mid_py", pixel_y, 1);
    @(negedge clk);
    rst = 1'b1;
    pix_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pix_en = 1'b0;
    chk("midrst_px", pixel_x, 799);
    chk("midrst_py", pixel_y, 524);
    chk("midrst_hs", hsync, 1);
    chk("midrst_vs", vsync, 1);
    chk("midrst_von", video_on, 0);
    chk("midrst_fs", frame_start, 0);
    tick();
    chk("restart_px", pixel_x, 0);
    chk("restart_py", pixel_y, 0);
    chk("restart_fs", frame_start, 1);

    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    chk("b_rst_px", px_b, 15);
    chk("b_rst_py", py_b, 7);
    chk("b_rst_hs", hs_b, 0);
    chk("b_rst_vs", vs_b, 0);
    chk("b_rst_von", von_b, 0);
    en_b = 1'b1;
    fs_cnt = 0;
    for (int k = 0; k <= 128; k++) begin
      int x, y;
      @(negedge clk);
      x = k % 16;
      y = (k / 16) % 8;
      chk("b_px", px_b, x);
      chk("b_py", py_b, y);
      chk("b_hs", hs_b, (x >= 10 && x < 13) ? 1 : 0);
      chk("b_vs", vs_b, (y >= 5 && y < 7) ? 1 : 0);
      chk("b_von", von_b, (x < 8 && y < 4) ? 1 : 0);
      chk("b_fs", fs_b, (x == 0 && y == 0) ? 1 : 0);
      if (fs_b) fs_cnt++;
    end
    chk("b_fs_count", fs_cnt, 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Consumes the pixel-rate enable that the clock divider derives from the 100 MHz board clock and generates 640x480@60 VGA timing. Outputs are hsync, vsync, video_on, the current pixel coordinates and a frame-start pulse. It sits between the clock divider and the radar pixel renderer/colour mux, and drives the VGA connector directly. All logic runs on the single board clock; it advances only on cycles where pix_en is high.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
CNT_W, 10, width of the counters and the pixel_x/pixel_y ports

Ports:
clk_in  input  1  board clock (100 MHz); single clock domain
rst  input  1  synchronous, active-high reset
pix_en  input  1  pixel-rate enable, nominally 1-in-4 cycles; one pixel advance per high cycle
hsync  output  1  horizontal sync, level per SYNC_POL
vsync  output  1  vertical sync, level per SYNC_POL
video_on  output  1  high while (pixel_x, pixel_y) is inside the active area
pixel_x  output  CNT_W  current horizontal count, 0..H_TOTAL-1
pixel_y  output  CNT_W  current vertical count, 0..V_TOTAL-1
frame_start  output  1  one clk_in pulse when the position becomes (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset, synchronous on rst=1 at a clk_in edge:
  - h_cnt = H_TOTAL-1 (799), v_cnt = V_TOTAL-1 (524).
  - hsync = vsync = ~SYNC_POL; video_on = 0; frame_start = 0.
  - Effect: the first pix_en after reset wraps to (0,0) and fires frame_start.
- rst has priority over pix_en. Reset mid-frame abandons the frame immediately, with no partial-line completion.
- On a clk_in edge with pix_en=1:
  - If h_cnt == H_TOTAL-1: h_cnt wraps to 0, and v_cnt advances (V_TOTAL-1 wraps to 0, otherwise +1).
  - Otherwise h_cnt+1, v_cnt unchanged.
- pix_en=0: counters and all level outputs hold. frame_start = 0.
- All outputs are registered and decoded from the next-state counter values, so every output is consistent with pixel_x/pixel_y in the same cycle. Latency is one clk_in edge from pix_en to updated outputs.
- pixel_x = h_cnt and pixel_y = v_cnt, unsigned, with no saturation.
- hsync = SYNC_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751), else ~SYNC_POL.
- vsync = SYNC_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), else ~SYNC_POL. vsync transitions coincide with h_cnt wrapping to 0.
- video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- frame_start = 1 for exactly one clk_in cycle, on the edge where pix_en=1 and the next state is (0,0). It is 0 otherwise.
- pix_en held high continuously is legal: the block runs at clk_in rate with identical sequencing.
- There is no state machine beyond the two cascaded modulo counters. Boundaries are at the h wrap (799→0), the v wrap (524→0) and the simultaneous h+v wrap.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480@60 timing constants (the parameter defaults);
  - derived H_TOTAL, V_TOTAL and the sync start/end constants;
  - the CNT_W constant.
- One natural sub-module, mod_counter (parameters MODULUS, WIDTH, RESET_VAL). It has inputs en, clk_in and rst, and outputs count and wrap. It is instantiated twice: the horizontal wrap drives the vertical enable.

Test Plan:
- Reset then pix_en 1-in-4: first pix_en → pixel_x=0, pixel_y=0, video_on=1, frame_start=1 for one cycle. Next pix_en → pixel_x=1, frame_start=0.
- One full line: video_on falls at pixel_x=640. hsync low exactly for pixel_x 656..751 (96 pix_en ticks). Wrap 799→0 increments pixel_y to 1.
- Full frame: vsync low for lines 490..491 only. video_on=0 for lines 480..524. After 800*525 = 420000 pix_en ticks, frame_start fires again at (0,0).
- pix_en held low for 100 cycles mid-line at pixel_x=300: all outputs hold, and no frame_start.
- rst asserted at (700,200) together with pix_en=1: next edge gives pixel_x=799, pixel_y=524, hsync=vsync=1, video_on=0.
- SYNC_POL=1 build: hsync high only during 656..751 and vsync high only during 490..491. pix_en tied high gives the same sequence at clk_in rate.
